uart_cmd_responder: RTL and testbench

- Command/response stage between the Uart controller's receive FIFO output and its transmit input.
- Consumes one received byte at a time and classifies it.
- Digits '0'..'9' produce the reply "return:<digit>\n". CR/LF are discarded silently. Any other byte produces the reply "error\n".
- Also exports the last accepted digit and an error counter for the seven-segment/LED display path.

---
 rtl/uart_cmd_pkg.sv | 37 +++
 rtl/uart_cmd_responder_if.sv | 26 ++
 rtl/uart_msg_rom.sv | 52 +++++
 rtl/uart_cmd_responder.sv | 118 +++++++++++
 tb/tb_uart_cmd_responder.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_cmd_pkg.sv
// ----------------------------------------------------------------------------
// uart_cmd_pkg : states, reply lengths and ASCII constants for the responder
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package uart_cmd_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SEND_RET = 2'd1,
    SEND_ERR = 2'd2
  } state_t;

  localparam logic [3:0] RET_LEN = 4'd9;
  localparam logic [3:0] ERR_LEN = 4'd6;

  // Names are upper case; the values are the lower-case letters of the replies.
  localparam logic [7:0] CH_CR    = 8'h0D;
  localparam logic [7:0] CH_LF    = 8'h0A;
  localparam logic [7:0] CH_0     = 8'h30;
  localparam logic [7:0] CH_9     = 8'h39;
  localparam logic [7:0] CH_R     = 8'h72;
  localparam logic [7:0] CH_E     = 8'h65;
  localparam logic [7:0] CH_T     = 8'h74;
  localparam logic [7:0] CH_U     = 8'h75;
  localparam logic [7:0] CH_N     = 8'h6E;
  localparam logic [7:0] CH_O     = 8'h6F;
  localparam logic [7:0] CH_COLON = 8'h3A;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= CH_0) && (b <= CH_9);
  endfunction

endpackage

`default_nettype wire

// File: rtl/uart_cmd_responder_if.sv
// ----------------------------------------------------------------------------
// uart_cmd_responder_if : RX-FIFO and TX valid/ready byte streams
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

interface uart_cmd_responder_if;
  logic [7:0] RxData;
  logic       RxData_valid;
  logic       RxData_ready;
  logic [7:0] TxData;
  logic       TxData_valid;
  logic       TxData_ready;

  modport slave (
    input  RxData, RxData_valid, TxData_ready,
    output RxData_ready, TxData, TxData_valid
  );

  modport master (
    output RxData, RxData_valid, TxData_ready,
    input  RxData_ready, TxData, TxData_valid
  );
endinterface

`default_nettype wire

// File: rtl/uart_msg_rom.sv
// ----------------------------------------------------------------------------
// uart_msg_rom : combinational reply text lookup by (message, index, digit)
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_msg_rom
  import uart_cmd_pkg::*;
#(
  parameter logic [7:0] TERM_CHAR = 8'h0A
) (
  input  state_t     i_sel,
  input  logic [3:0] i_idx,
  input  logic [7:0] i_rx_buf,
  output logic [7:0] o_byte
);

  always_comb begin
    o_byte = 8'h00;
    case (i_sel)
      SEND_RET: begin
        case (i_idx)
          4'd0:    o_byte = CH_R;
          4'd1:    o_byte = CH_E;
          4'd2:    o_byte = CH_T;
          4'd3:    o_byte = CH_U;
          4'd4:    o_byte = CH_R;
          4'd5:    o_byte = CH_N;
          4'd6:    o_byte = CH_COLON;
          4'd7:    o_byte = i_rx_buf;
          4'd8:    o_byte = TERM_CHAR;
          default: o_byte = 8'h00;
        endcase
      end
      SEND_ERR: begin
        case (i_idx)
          4'd0:    o_byte = CH_E;
          4'd1:    o_byte = CH_R;
          4'd2:    o_byte = CH_R;
          4'd3:    o_byte = CH_O;
          4'd4:    o_byte = CH_R;
          4'd5:    o_byte = TERM_CHAR;
          default: o_byte = 8'h00;
        endcase
      end
      default: o_byte = 8'h00;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/uart_cmd_responder.sv
// ----------------------------------------------------------------------------
// uart_cmd_responder : classifies RX bytes and streams the return/error replies
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module uart_cmd_responder
    import uart_cmd_pkg::*;
#(
    parameter int         CNT_W     = 8,
    parameter logic [7:0] TERM_CHAR = 8'h0A
) (
    input  logic                 sysClk,
    input  logic                 sysRst,
    uart_cmd_responder_if.slave  bus,
    output logic [3:0]           lastDigit,
    output logic                 digitSeen,
    output logic [CNT_W-1:0]     errCount,
    output logic                 busy
);

    state_t             r_state, w_state_nxt;
    logic [3:0]         r_idx, w_idx_nxt;
    logic [7:0]         r_rx_buf, w_rx_buf_nxt;
    logic [3:0]         r_last_digit, w_last_digit_nxt;
    logic               r_digit_seen, w_digit_seen_nxt;
    logic [CNT_W-1:0]   r_err_cnt, w_err_cnt_nxt;
    logic               r_rx_ready, r_tx_valid, r_busy;
    logic [7:0]         r_tx_data;
    logic [7:0]         w_rom_byte;
    logic               w_rx_fire, w_tx_fire;
    logic [3:0]         w_last_idx;

    assign w_rx_fire  = r_rx_ready & bus.RxData_valid;
    assign w_tx_fire  = r_tx_valid & bus.TxData_ready;
    assign w_last_idx = (r_state == SEND_RET) ? (RET_LEN - 4'd1) : (ERR_LEN - 4'd1);

    always_comb begin
        w_state_nxt      = r_state;
        w_idx_nxt        = r_idx;
        w_rx_buf_nxt     = r_rx_buf;
        w_last_digit_nxt = r_last_digit;
        w_digit_seen_nxt = r_digit_seen;
        w_err_cnt_nxt    = r_err_cnt;
        case (r_state)
            IDLE: begin
                if (w_rx_fire) begin
                    w_rx_buf_nxt = bus.RxData;
                    w_idx_nxt    = 4'd0;
                    if (is_digit(bus.RxData)) begin
                        w_state_nxt      = SEND_RET;
                        w_last_digit_nxt = bus.RxData[3:0];
                        w_digit_seen_nxt = 1'b1;
                    end else if (bus.RxData != CH_CR && bus.RxData != CH_LF) begin
                        w_state_nxt = SEND_ERR;
                        if (!(&r_err_cnt)) w_err_cnt_nxt = r_err_cnt + CNT_W'(1);
                    end
                end
            end
            SEND_RET, SEND_ERR: begin
                if (w_tx_fire) begin
                    if (r_idx == w_last_idx) begin
                        w_state_nxt = IDLE;
                        w_idx_nxt   = 4'd0;
                    end else begin
                        w_idx_nxt = r_idx + 4'd1;
                    end
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // Looked up from next-state values so TxData is registered yet bubble-free.
    uart_msg_rom #(.TERM_CHAR(TERM_CHAR)) u_rom (
        .i_sel    (w_state_nxt),
        .i_idx    (w_idx_nxt),
        .i_rx_buf (w_rx_buf_nxt),
        .o_byte   (w_rom_byte)
    );

    always_ff @(posedge sysClk or posedge sysRst) begin
        if (sysRst) begin
            r_state      <= IDLE;
            r_idx        <= 4'd0;
            r_rx_buf     <= 8'h00;
            r_last_digit <= 4'd0;
            r_digit_seen <= 1'b0;
            r_err_cnt    <= '0;
            r_rx_ready   <= 1'b0;
            r_tx_valid   <= 1'b0;
            r_tx_data    <= 8'h00;
            r_busy       <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_idx        <= w_idx_nxt;
            r_rx_buf     <= w_rx_buf_nxt;
            r_last_digit <= w_last_digit_nxt;
            r_digit_seen <= w_digit_seen_nxt;
            r_err_cnt    <= w_err_cnt_nxt;
            r_rx_ready   <= (w_state_nxt == IDLE);
            r_tx_valid   <= (w_state_nxt != IDLE);
            r_busy       <= (w_state_nxt != IDLE);
            r_tx_data    <= w_rom_byte;
        end
    end

    assign bus.RxData_ready = r_rx_ready;
    assign bus.TxData_valid = r_tx_valid;
    assign bus.TxData       = r_tx_data;
    assign lastDigit        = r_last_digit;
    assign digitSeen        = r_digit_seen;
    assign errCount         = r_err_cnt;
    assign busy             = r_busy;

endmodule

`default_nettype wire

// File: tb/tb_uart_cmd_responder.sv
// ----------------------------------------------------------------------------
// tb_uart_cmd_responder : scenario tasks checked against a reply-text model
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_uart_cmd_responder;

  localparam int CNT_W   = 2;
  localparam int ERR_MAX = 3;

  logic             sysClk = 1'b0;
  logic             sysRst;
  logic [3:0]       lastDigit;
  logic             digitSeen;
  logic [CNT_W-1:0] errCount;
  logic             busy;

  uart_cmd_responder_if bus_if ();

  uart_cmd_responder #(.CNT_W(CNT_W), .TERM_CHAR(8'h0A)) dut (
    .sysClk    (sysClk),
    .sysRst    (sysRst),
    .bus       (bus_if),
    .lastDigit (lastDigit),
    .digitSeen (digitSeen),
    .errCount  (errCount),
    .busy      (busy)
  );

  always #5 sysClk = ~sysClk;

  int         tests = 0;
  int         fails = 0;
  logic [7:0] exp_q[$];
  int         m_last, m_seen, m_err;

  // Reference: reply text built from strings, counters from plain arithmetic.
  task automatic model_accept(input logic [7:0] b);
    string s;
    if (b >= 8'h30 && b <= 8'h39) begin
      s = "return:";
      for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
      exp_q.push_back(b);
      exp_q.push_back(8'h0A);
      m_last = int'(b) - 48;
      m_seen = 1;
    end else if (b != 8'h0D && b != 8'h0A) begin
      s = "error";
      for (int i = 0; i < s.len(); i++) exp_q.push_back(s[i]);
      exp_q.push_back(8'h0A);
      m_err = (m_err < ERR_MAX) ? m_err + 1 : ERR_MAX;
    end
  endtask

  task automatic do_rx(input logic [7:0] b, output int waited);
    bit r;
    waited = 0;
    bus_if.RxData       = b;
    bus_if.RxData_valid = 1'b1;
    forever begin
      r = bus_if.RxData_ready;
      @(posedge sysClk); #1;
      if (r) break;
      waited++;
      if (waited > 100) begin
        tests++; fails++;
        $display("FAIL rx_accept_timeout: byte %02h never accepted", b);
        break;
      end
    end
    bus_if.RxData_valid = 1'b0;
    model_accept(b);
  endtask

  // mode 0: ready held high, 1: ready pattern 1,0,0 repeating, 2: random ready
  task automatic collect(input int mode, input bit chk_blocked);
    int n, got, cycles, k;
    bit rdy, v, prev_stall;
    logic [7:0] prev_data;
    n = exp_q.size(); got = 0; cycles = 0; k = 0; prev_stall = 0; prev_data = 8'h00;
    while (got < n && cycles < 300) begin
      v = bus_if.TxData_valid;
      tests++;
      if (v !== 1'b1) begin
        fails++; $display("FAIL tx_valid_gap: valid=%b at byte %0d, required 1", v, got);
      end
      tests++;
      if (busy !== 1'b1) begin
        fails++; $display("FAIL busy_during_reply: busy=%b, required 1", busy);
      end
      if (prev_stall) begin
        tests++;
        if (bus_if.TxData !== prev_data) begin
          fails++; $display("FAIL stall_hold: TxData=%02h, required %02h", bus_if.TxData, prev_data);
        end
      end
      if (chk_blocked) begin
        tests++;
        if (bus_if.RxData_ready !== 1'b0) begin
          fails++; $display("FAIL rx_blocked: RxData_ready=%b during reply, required 0", bus_if.RxData_ready);
        end
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = (k % 3 == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      k++;
      bus_if.TxData_ready = rdy;
      prev_data  = bus_if.TxData;
      prev_stall = !rdy;
      @(posedge sysClk); #1;
      cycles++;
      if (rdy && v) begin
        tests++;
        if (prev_data !== exp_q[got]) begin
          fails++; $display("FAIL tx_byte[%0d]: got %02h, required %02h", got, prev_data, exp_q[got]);
        end
        got++;
      end
    end
    bus_if.TxData_ready = 1'b0;
    if (got < n) begin
      tests++; fails++;
      $display("FAIL reply_timeout: %0d of %0d bytes", got, n);
    end
    if (mode == 0 && n > 0) begin
      tests++;
      if (cycles != n) begin
        fails++; $display("FAIL reply_cycles: took %0d, required %0d", cycles, n);
      end
    end
    tests++;
    if (bus_if.TxData_valid !== 1'b0 || bus_if.RxData_ready !== 1'b1 || busy !== 1'b0) begin
      fails++;
      $display("FAIL after_reply: valid=%b ready=%b busy=%b, required 0 1 0",
               bus_if.TxData_valid, bus_if.RxData_ready, busy);
    end
    exp_q.delete();
  endtask

  task automatic test_reset();
    sysRst = 1'b1;
    bus_if.RxData = 8'h00; bus_if.RxData_valid = 1'b0; bus_if.TxData_ready = 1'b0;
    repeat (2) @(posedge sysClk);
    #1;
    tests++;
    if (bus_if.RxData_ready !== 1'b0 || bus_if.TxData_valid !== 1'b0 || bus_if.TxData !== 8'h00 ||
        lastDigit !== 4'd0 || digitSeen !== 1'b0 || errCount !== '0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_values: rdy=%b vld=%b data=%02h last=%0d seen=%b err=%0d busy=%b, required all 0",
               bus_if.RxData_ready, bus_if.TxData_valid, bus_if.TxData, lastDigit, digitSeen, errCount, busy);
    end
    sysRst = 1'b0;
    m_last = 0; m_seen = 0; m_err = 0; exp_q.delete();
    @(posedge sysClk); #1;
    tests++;
    if (bus_if.RxData_ready !== 1'b1) begin
      fails++; $display("FAIL idle_ready: RxData_ready=%b, required 1", bus_if.RxData_ready);
    end
  endtask

  task automatic check_status(input string tag);
    tests++;
    if (lastDigit !== 4'(m_last) || digitSeen !== 1'(m_seen) || errCount !== CNT_W'(m_err)) begin
      fails++;
      $display("FAIL status_%s: last=%0d seen=%b err=%0d, required %0d %0d %0d",
               tag, lastDigit, digitSeen, errCount, m_last, m_seen, m_err);
    end
  endtask

  task automatic test_digit();
    int w;
    do_rx(8'h35, w);
    collect(0, 0);
    check_status("digit");
  endtask

  task automatic test_error();
    int w;
    do_rx(8'h41, w);
    collect(0, 0);
    check_status("error");
  endtask

  task automatic test_backpressure();
    int w;
    do_rx(8'h37, w);
    collect(1, 0);
    check_status("backpressure");
  endtask

  task automatic test_crlf();
    int w;
    do_rx(8'h0D, w);
    collect(0, 0);
    do_rx(8'h0A, w);
    tests++;
    if (w != 0) begin
      fails++; $display("FAIL lf_consecutive: waited %0d cycles, required 0", w);
    end
    collect(0, 0);
    check_status("crlf");
  endtask

  task automatic test_back_to_back();
    int w;
    do_rx(8'h41, w);
    bus_if.RxData       = 8'h33;
    bus_if.RxData_valid = 1'b1;
    collect(0, 1);
    @(posedge sysClk); #1;
    bus_if.RxData_valid = 1'b0;
    model_accept(8'h33);
    collect(0, 0);
    check_status("back_to_back");
  endtask

  task automatic test_random();
    int w;
    logic [7:0] b;
    for (int i = 0; i < 16; i++) begin
      case ($urandom_range(0, 3))
        0:       b = 8'(8'h30 + $urandom_range(0, 9));
        1:       b = ($urandom_range(0, 1) != 0) ? 8'h0D : 8'h0A;
        default: b = 8'($urandom_range(0, 255));
      endcase
      do_rx(b, w);
      collect(2, 0);
      check_status("random");
    end
  endtask

  task automatic test_saturate_and_reset();
    int w;
    test_reset();
    for (int i = 0; i < 4; i++) begin
      do_rx(8'(8'h41 + i), w);
      collect(0, 0);
      check_status("saturate");
    end
    do_rx(8'h5A, w);
    bus_if.TxData_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tests++;
      if (bus_if.TxData !== exp_q[i]) begin
        fails++; $display("FAIL partial_byte[%0d]: got %02h, required %02h", i, bus_if.TxData, exp_q[i]);
      end
      @(posedge sysClk); #1;
    end
    bus_if.TxData_ready = 1'b0;
    check_status("fifth");
    sysRst = 1'b1;
    #1;
    tests++;
    if (bus_if.TxData_valid !== 1'b0 || errCount !== '0 || busy !== 1'b0 || digitSeen !== 1'b0) begin
      fails++;
      $display("FAIL async_reset: valid=%b err=%0d busy=%b seen=%b, required 0 0 0 0",
               bus_if.TxData_valid, errCount, busy, digitSeen);
    end
    @(posedge sysClk); #1;
    sysRst = 1'b0;
    exp_q.delete(); m_last = 0; m_seen = 0; m_err = 0;
    @(posedge sysClk); #1;
    tests++;
    if (bus_if.RxData_ready !== 1'b1 || bus_if.TxData_valid !== 1'b0) begin
      fails++;
      $display("FAIL idle_after_reset: ready=%b valid=%b, required 1 0",
               bus_if.RxData_ready, bus_if.TxData_valid);
    end
    do_rx(8'h39, w);
    collect(0, 0);
    check_status("after_reset");
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_digit();
    test_error();
    test_backpressure();
    test_crlf();
    test_back_to_back();
    test_random();
    test_saturate_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
